// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU and the -W forms when XLEN=64).
//
// Multiplies complete a fixed MUL_LATENCY cycles after accept. Divides whose
// result is fully determined by the corner-case rules (divide by zero, signed
// overflow) complete one cycle after accept. All other divides use an iterative
// restoring divider that produces one quotient bit per cycle, followed by a
// one-cycle sign fixup.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           kills any in-flight op; the result is dropped
//   in_valid/ready  request handshake; in_ready only in IDLE, never in reset/flush
//   a, b            rs1, rs2 (latched at accept)
//   funct3          M-extension funct3
//   width_32        -W variant (ignored when XLEN=32)
//   in_tag/out_tag  opaque tag carried with the op
//   out_valid/ready result handshake; result/out_tag held until out_ready
//   result          XLEN-bit result
//   busy            unit is not IDLE
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | waiting for an op; in_ready high unless reset/flush
// S_MUL        | multiply latency down-counter running; product taken at zero
// S_DIV_SPECIAL| divide-by-zero or signed overflow; fixed result next edge
// S_DIV_RUN    | restoring divider, one quotient bit per cycle, then fixup
// S_DONE       | out_valid high, result/out_tag held until out_ready

module muldiv_unit #(
    parameter int XLEN        = 64,
    parameter int MUL_LATENCY = 3,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [2:0]       funct3,
    input  logic             width_32,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV_SPECIAL,
        S_DIV_RUN,
        S_DONE
    } state_t;

    state_t state;

    // Latched operands; the inputs may change freely after accept.
    logic [XLEN-1:0]  a_q;
    logic [XLEN-1:0]  b_q;
    logic [1:0]       op_q;
    logic             w_q;
    logic [TAG_W-1:0] tag_q;

    // Shared down-counter: multiply latency or remaining quotient bits.
    logic [CNT_W-1:0] iter_cnt;

    // Divider datapath (unsigned magnitudes).
    logic [XLEN-1:0]  div_rem;
    logic [XLEN-1:0]  div_quo;
    logic [XLEN-1:0]  div_dvs;
    logic             neg_quo;
    logic             neg_rem;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction

    assign in_ready = (state == S_IDLE) && !reset && !flush;
    assign busy     = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Input-side decode, evaluated at the accept edge
    // ------------------------------------------------------------------
    logic            w_in;
    logic            in_signed;
    logic            in_b_zero;
    logic            in_ovf;
    logic            neg_a_in;
    logic            neg_b_in;
    logic [31:0]     a32_mag;
    logic [31:0]     b32_mag;
    logic [XLEN-1:0] dvd_mag_in;
    logic [XLEN-1:0] dvs_mag_in;

    assign w_in = (XLEN == 64) && width_32;

    always_comb begin
        in_signed  = ~funct3[0];
        in_b_zero  = 1'b0;
        in_ovf     = 1'b0;
        neg_a_in   = 1'b0;
        neg_b_in   = 1'b0;
        a32_mag    = '0;
        b32_mag    = '0;
        dvd_mag_in = '0;
        dvs_mag_in = '0;
        if (w_in) begin
            in_b_zero  = (b[31:0] == '0);
            in_ovf     = in_signed && (a[31:0] == 32'h8000_0000) && (b[31:0] == '1);
            neg_a_in   = in_signed && a[31];
            neg_b_in   = in_signed && b[31];
            a32_mag    = neg_a_in ? -a[31:0] : a[31:0];
            b32_mag    = neg_b_in ? -b[31:0] : b[31:0];
            // The 32-bit dividend sits at the top so quotient bits shift out
            // of the same MSB as a full-width divide; after 32 steps the
            // quotient occupies the low 32 bits.
            dvd_mag_in = XLEN'(a32_mag) << (XLEN - 32);
            dvs_mag_in = XLEN'(b32_mag);
        end else begin
            in_b_zero  = (b == '0);
            in_ovf     = in_signed && (a == XLEN_MIN) && (b == '1);
            neg_a_in   = in_signed && a[XLEN-1];
            neg_b_in   = in_signed && b[XLEN-1];
            dvd_mag_in = neg_a_in ? -a : a;
            dvs_mag_in = neg_b_in ? -b : b;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier: both operands extended to 2*XLEN so the low 2*XLEN bits of
    // an unsigned product are the correct signed/mixed/unsigned product.
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0]   mul_res;

    always_comb begin
        mul_a = {{XLEN{1'b0}}, a_q};
        mul_b = {{XLEN{1'b0}}, b_q};
        if (op_q == 2'd1 || op_q == 2'd2) begin
            mul_a = {{XLEN{a_q[XLEN-1]}}, a_q};
        end
        if (op_q == 2'd1) begin
            mul_b = {{XLEN{b_q[XLEN-1]}}, b_q};
        end
        mul_p = mul_a * mul_b;
        if (w_q) begin
            mul_res = sext32(mul_p[31:0]);
        end else if (op_q == 2'd0) begin
            mul_res = mul_p[XLEN-1:0];
        end else begin
            mul_res = mul_p[2*XLEN-1:XLEN];
        end
    end

    // ------------------------------------------------------------------
    // Divider corner-case result (from latched operands)
    // op_q[1] distinguishes REM/REMU from DIV/DIVU.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] dvd_ext;
    logic            b_zero_q;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        dvd_ext  = w_q ? sext32(a_q[31:0]) : a_q;
        b_zero_q = w_q ? (b_q[31:0] == '0) : (b_q == '0);
        if (b_zero_q) begin
            spec_res = op_q[1] ? dvd_ext : '1;
        end else begin
            // Signed overflow: quotient is the dividend, remainder is zero.
            spec_res = op_q[1] ? '0 : dvd_ext;
        end
    end

    // ------------------------------------------------------------------
    // Restoring divider step and sign fixup
    // ------------------------------------------------------------------
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic [31:0]     q32;
    logic [31:0]     r32;
    logic [XLEN-1:0] q_full;
    logic [XLEN-1:0] r_full;
    logic [XLEN-1:0] div_res;

    always_comb begin
        rem_sh   = {div_rem, div_quo[XLEN-1]};
        rem_diff = rem_sh - {1'b0, div_dvs};
        q32      = neg_quo ? -div_quo[31:0] : div_quo[31:0];
        r32      = neg_rem ? -div_rem[31:0] : div_rem[31:0];
        q_full   = neg_quo ? -div_quo : div_quo;
        r_full   = neg_rem ? -div_rem : div_rem;
        if (w_q) begin
            div_res = op_q[1] ? sext32(r32) : sext32(q32);
        end else begin
            div_res = op_q[1] ? r_full : q_full;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            out_tag   <= '0;
            iter_cnt  <= '0;
        end else if (flush) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            iter_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= funct3[1:0];
                        w_q   <= w_in;
                        tag_q <= in_tag;
                        if (!funct3[2]) begin
                            state    <= S_MUL;
                            iter_cnt <= CNT_W'(MUL_LATENCY - 1);
                        end else if (in_b_zero || in_ovf) begin
                            state <= S_DIV_SPECIAL;
                        end else begin
                            state    <= S_DIV_RUN;
                            iter_cnt <= w_in ? CNT_W'(32) : CNT_W'(XLEN);
                            div_rem  <= '0;
                            div_quo  <= dvd_mag_in;
                            div_dvs  <= dvs_mag_in;
                            neg_quo  <= neg_a_in ^ neg_b_in;
                            neg_rem  <= neg_a_in;
                        end
                    end
                end

                S_MUL: begin
                    if (iter_cnt == '0) begin
                        result    <= mul_res;
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        iter_cnt <= iter_cnt - 1'b1;
                    end
                end

                S_DIV_SPECIAL: begin
                    result    <= spec_res;
                    out_tag   <= tag_q;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end

                S_DIV_RUN: begin
                    if (iter_cnt == '0) begin
                        // All quotient bits produced; this edge applies signs.
                        result    <= div_res;
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        iter_cnt <= iter_cnt - 1'b1;
                        if (!rem_diff[XLEN]) begin
                            div_rem <= rem_diff[XLEN-1:0];
                            div_quo <= {div_quo[XLEN-2:0], 1'b1};
                        end else begin
                            div_rem <= rem_sh[XLEN-1:0];
                            div_quo <= {div_quo[XLEN-2:0], 1'b0};
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int XLEN        = 64;
    localparam int MUL_LATENCY = 3;
    localparam int TAG_W       = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [2:0]        funct3;
    logic              width_32;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [XLEN-1:0]   result;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;

    muldiv_unit #(
        .XLEN(XLEN),
        .MUL_LATENCY(MUL_LATENCY),
        .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .funct3(funct3),
        .width_32(width_32),
        .in_tag(in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result(result),
        .out_tag(out_tag),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  tag;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] sx32(input logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] ref_result(input logic [63:0] ra, input logic [63:0] rb,
                                               input logic [2:0] f3, input logic w);
        logic [127:0]    p;
        logic [31:0]     r32;
        int              sa32, sb32;
        int unsigned     ua32, ub32;
        longint          sa, sbv;
        longint unsigned ua, ub;
        logic [63:0]     r;
        if (!f3[2]) begin
            if (w) begin
                r32 = ra[31:0] * rb[31:0];
                return sx32(r32);
            end
            case (f3[1:0])
                2'd0: return ra * rb;
                2'd1: p = {{64{ra[63]}}, ra} * {{64{rb[63]}}, rb};
                2'd2: p = {{64{ra[63]}}, ra} * {64'd0, rb};
                default: p = {64'd0, ra} * {64'd0, rb};
            endcase
            return p[127:64];
        end
        if (w) begin
            sa32 = ra[31:0]; sb32 = rb[31:0]; ua32 = ra[31:0]; ub32 = rb[31:0];
            case (f3)
                3'd4: if (sb32 == 0) r32 = '1;
                      else if (sa32 == 32'sh80000000 && sb32 == -1) r32 = sa32;
                      else r32 = sa32 / sb32;
                3'd5: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
                3'd6: if (sb32 == 0) r32 = sa32;
                      else if (sa32 == 32'sh80000000 && sb32 == -1) r32 = 0;
                      else r32 = sa32 % sb32;
                default: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
            endcase
            return sx32(r32);
        end
        sa = ra; sbv = rb; ua = ra; ub = rb;
        case (f3)
            3'd4: if (sbv == 0) r = '1;
                  else if (sa == 64'sh8000000000000000 && sbv == -1) r = sa;
                  else r = sa / sbv;
            3'd5: if (ub == 0) r = '1; else r = ua / ub;
            3'd6: if (sbv == 0) r = sa;
                  else if (sa == 64'sh8000000000000000 && sbv == -1) r = 0;
                  else r = sa % sbv;
            default: if (ub == 0) r = ua; else r = ua % ub;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [63:0] ra, input logic [63:0] rb,
                                       input logic [2:0] f3, input logic w);
        logic zero, ovf;
        if (!f3[2]) return MUL_LATENCY;
        zero = w ? (rb[31:0] == 0) : (rb == 0);
        ovf  = !f3[0] && (w ? (ra[31:0] == 32'h80000000 && rb[31:0] == 32'hFFFFFFFF)
                            : (ra == 64'h8000000000000000 && rb == '1));
        if (zero || ovf) return 1;
        return w ? 33 : 65;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        seen = 1'b0;
    logic [63:0] hold_res;
    logic [4:0]  hold_tag;
    int          bp_cnt  = 0;
    int          bp_next = 0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            seen      = 1'b0;
            out_ready = 1'b0;
            bp_cnt    = 0;
        end else if (out_valid) begin
            if (!seen) begin
                seen     = 1'b1;
                hold_res = result;
                hold_tag = out_tag;
                bp_cnt   = bp_next;
                bp_next  = 0;
                check("unexpected_out", 64'(sb.size() == 0), 64'd0);
                if (sb.size() > 0) check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            end else begin
                check("hold_result", result, hold_res);
                check("hold_tag", 64'(out_tag), 64'(hold_tag));
            end
            check("in_ready_in_done", 64'(in_ready), 64'd0);
            if (bp_cnt > 0) begin
                bp_cnt--;
                out_ready = 1'b0;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            if (out_ready) begin
                seen = 1'b0;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("tag", 64'(out_tag), 64'(e.tag));
                end
            end
        end else begin
            seen      = 1'b0;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic [2:0] f3,
                         input logic w, input logic [4:0] tg, input logic [63:0] eres,
                         input int elat, input bit track, output int acc);
        int guard;
        guard = 0;
        acc   = -1;
        @(negedge clk);
        while (!in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("issue_timeout", 64'(in_ready), 64'd1);
            return;
        end
        a = ia; b = ib; funct3 = f3; width_32 = w; in_tag = tg;
        in_valid = 1'b1;
        acc = cyc + 1;
        if (track) sb.push_back('{res: eres, tag: tg, lat: elat, acc: acc});
        @(negedge clk);
        in_valid = 1'b0;
        a        = {$urandom, $urandom};
        b        = {$urandom, $urandom};
        funct3   = 3'($urandom);
        width_32 = 1'($urandom);
        in_tag   = 5'($urandom);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || busy) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    task automatic run_model(input logic [63:0] ia, input logic [63:0] ib, input logic [2:0] f3,
                             input logic w, input logic [4:0] tg);
        int acc;
        issue(ia, ib, f3, w, tg, ref_result(ia, ib, f3, w), ref_latency(ia, ib, f3, w), 1'b1, acc);
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 6))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {$urandom, 32'h8000_0000};
            4: return 64'($urandom_range(0, 20));
            5: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; funct3 = '0; width_32 = 1'b0; in_tag = '0;
        repeat (3) @(negedge clk);
        check("ready_in_reset", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_out_tag", 64'(out_tag), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 64'(in_ready), 64'd1);

        // directed vectors with hand-derived expectations
        issue('1, 64'd2, 3'd1, 1'b0, 5'd7, '1, 3, 1'b1, acc);                    // MULH
        drain();
        issue('1, 64'd2, 3'd3, 1'b0, 5'd3, 64'd1, 3, 1'b1, acc);                 // MULHU
        issue('1, 64'd2, 3'd2, 1'b0, 5'd4, '1, 3, 1'b1, acc);                    // MULHSU
        issue(-64'd7, 64'd2, 3'd4, 1'b0, 5'd5, -64'd3, 65, 1'b1, acc);          // DIV
        issue(-64'd7, 64'd2, 3'd6, 1'b0, 5'd6, -64'd1, 65, 1'b1, acc);          // REM
        issue(64'h0000_0000_FFFF_FFFE, 64'd1, 3'd5, 1'b1, 5'd8,
              64'hFFFF_FFFF_FFFF_FFFE, 33, 1'b1, acc);                           // DIVUW
        issue(64'd123, 64'd0, 3'd4, 1'b0, 5'd9, '1, 1, 1'b1, acc);               // DIV /0
        issue(64'd5, 64'd0, 3'd7, 1'b0, 5'd10, 64'd5, 1, 1'b1, acc);             // REMU /0
        issue(64'h8000_0000_0000_0000, '1, 3'd4, 1'b0, 5'd11,
              64'h8000_0000_0000_0000, 1, 1'b1, acc);                            // DIV ovf
        issue(64'h8000_0000, '1, 3'd6, 1'b1, 5'd12, 64'd0, 1, 1'b1, acc);         // REMW ovf
        drain();

        // backpressure: 10 cycles with out_ready low in DONE
        bp_next = 10;
        issue(64'd6, 64'd7, 3'd0, 1'b0, 5'd13, 64'd42, 3, 1'b1, acc);
        drain();

        // reset in the middle of a divide clears result and tag
        issue(64'd1000, 64'd3, 3'd4, 1'b0, 5'd14, 64'd0, 0, 1'b0, acc);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_result", result, 64'd0);
        check("midreset_tag", 64'(out_tag), 64'd0);
        check("midreset_valid", 64'(out_valid), 64'd0);
        check("midreset_busy", 64'(busy), 64'd0);

        // flush at cycle 20 of a divide
        issue(64'd999_999, 64'd7, 3'd4, 1'b0, 5'd15, 64'd0, 0, 1'b0, acc);
        while (cyc < acc + 20) @(negedge clk);
        flush = 1'b1;
        #1;
        check("ready_in_flush", 64'(in_ready), 64'd0);
        check("busy_before_flush", 64'(busy), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        check("flush_ready_c22", 64'(in_ready), 64'd1);
        check("flush_busy_c22", 64'(busy), 64'd0);
        repeat (80) @(negedge clk);

        // in_valid together with flush is not accepted
        a = 64'd3; b = 64'd3; funct3 = 3'd0; width_32 = 1'b0; in_tag = 5'd1;
        in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_blocks_accept", 64'(busy), 64'd0);

        issue(64'd12345, 64'd1000, 3'd0, 1'b0, 5'd16, 64'd12_345_000, 3, 1'b1, acc);
        drain();

        // randomized ops against the reference model
        for (int i = 0; i < 80; i++) begin
            run_model(rnd_op(), rnd_op(), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 2) == 0), 5'($urandom));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
